linebuf_window_ctrl: RTL and testbench

LINEBUF_WINDOW_CTRL -- requirements
Module: linebuf_window_ctrl

---
 rtl/linebuf_pkg.sv | 14 +
 rtl/linebuf_window_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_linebuf_window_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/linebuf_pkg.sv
// Shared types and constants for the 3-row line-buffer window controller.
// Contents: FSM state type (S_RD, S_WR), row-count width and the
// row count at which a full 3-row column is available.
package linebuf_pkg;

   typedef enum logic {
      S_RD = 1'b0,
      S_WR = 1'b1
   } state_e;

   localparam int unsigned ROW_CNT_W = 2;
   localparam int unsigned ROW_FULL  = 2;

endpackage : linebuf_pkg

// File: rtl/linebuf_window_ctrl.sv
// 3-row sliding-window column generator backed by two external 1-cycle
// single-port RAMs (ram0 holds row n-1, ram1 holds row n-2).
// Each pixel costs two cycles: S_RD reads both buffers at the pixel's
// column, S_WR writes the shifted column back and registers the window.
// Ports:
//   clka, rsta_n          clock, async active-low reset
//   i_valid/i_ready       pixel handshake, i_sof marks first pixel of frame
//   i_data                input pixel
//   o_valid/o_eol/o_col   window column pulse, end-of-row flag, column
//   o_row0/1/2            pixels of rows n-2, n-1, n
//   ram0_*/ram1_*         row buffer ports (driven combinationally)
// Build option: LINEBUF_BORDER_ZERO_EN -- when defined, rows 0 and 1 are
// emitted with unfilled rows forced to 0; otherwise only complete
// 3-row columns are emitted.
module linebuf_window_ctrl
   import linebuf_pkg::*;
#(
   parameter int unsigned P_ROW_WIDTH  = 256,
   parameter int unsigned P_DATA_WIDTH = 8,
   parameter int unsigned P_ADDR_WIDTH = 12
) (
   input  logic                    clka,
   input  logic                    rsta_n,
   input  logic                    i_valid,
   input  logic                    i_sof,
   input  logic [P_DATA_WIDTH-1:0] i_data,
   output logic                    i_ready,
   output logic                    o_valid,
   output logic [P_DATA_WIDTH-1:0] o_row0,
   output logic [P_DATA_WIDTH-1:0] o_row1,
   output logic [P_DATA_WIDTH-1:0] o_row2,
   output logic [P_ADDR_WIDTH-1:0] o_col,
   output logic                    o_eol,
   output logic                    ram0_en,
   output logic                    ram0_we,
   output logic [P_ADDR_WIDTH-1:0] ram0_addr,
   output logic [P_DATA_WIDTH-1:0] ram0_din,
   input  logic [P_DATA_WIDTH-1:0] ram0_dout,
   output logic                    ram1_en,
   output logic                    ram1_we,
   output logic [P_ADDR_WIDTH-1:0] ram1_addr,
   output logic [P_DATA_WIDTH-1:0] ram1_din,
   input  logic [P_DATA_WIDTH-1:0] ram1_dout
);

   // Row must fit in the buffer address space.
   if (64'(P_ROW_WIDTH) > (64'd1 << P_ADDR_WIDTH)) begin : g_row_width_check
      $error("P_ROW_WIDTH exceeds 2**P_ADDR_WIDTH");
   end

   localparam logic [P_ADDR_WIDTH-1:0] LAST_COL = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
   localparam logic [ROW_CNT_W-1:0]    ROW_MAX  = ROW_CNT_W'(ROW_FULL);

   state_e                  state_q, state_d;
   logic                    ready_q, ready_d;
   logic [P_ADDR_WIDTH-1:0] col_q, col_d;
   logic [ROW_CNT_W-1:0]    row_q, row_d;
   logic [P_DATA_WIDTH-1:0] pix_q, pix_d;
   logic                    valid_q, valid_d;
   logic                    eol_q, eol_d;
   logic [P_DATA_WIDTH-1:0] row0_q, row0_d;
   logic [P_DATA_WIDTH-1:0] row1_q, row1_d;
   logic [P_DATA_WIDTH-1:0] row2_q, row2_d;
   logic [P_ADDR_WIDTH-1:0] ocol_q, ocol_d;

   logic                    accept_c;
   logic [P_ADDR_WIDTH-1:0] start_col_c;
   logic                    ram_en_c, ram_we_c;
   logic [P_ADDR_WIDTH-1:0] ram_addr_c;
   logic [P_DATA_WIDTH-1:0] ram0_din_c, ram1_din_c;

   // i_ready is a register so it stays low through reset and rises on
   // the first edge after release.
   assign accept_c    = i_valid & ready_q;
   assign start_col_c = i_sof ? '0 : col_q;

   // State register.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q <= S_RD;
         ready_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         pix_q   <= '0;
         valid_q <= 1'b0;
         eol_q   <= 1'b0;
         row0_q  <= '0;
         row1_q  <= '0;
         row2_q  <= '0;
         ocol_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
         valid_q <= valid_d;
         eol_q   <= eol_d;
         row0_q  <= row0_d;
         row1_q  <= row1_d;
         row2_q  <= row2_d;
         ocol_q  <= ocol_d;
      end
   end

   // Next-state, window and RAM port logic.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      pix_d      = pix_q;
      valid_d    = 1'b0;
      eol_d      = 1'b0;
      row0_d     = row0_q;
      row1_d     = row1_q;
      row2_d     = row2_q;
      ocol_d     = ocol_q;
      ram_en_c   = 1'b0;
      ram_we_c   = 1'b0;
      ram_addr_c = '0;
      ram0_din_c = '0;
      ram1_din_c = '0;

      unique case (state_q)
         S_RD: begin
            if (accept_c) begin
               pix_d      = i_data;
               col_d      = start_col_c;
               if (i_sof) row_d = '0;
               ram_en_c   = 1'b1;
               ram_addr_c = start_col_c;
               state_d    = S_WR;
            end
         end
         S_WR: begin
            // Shift the column down: new pixel into ram0, old row n-1 into ram1.
            ram_en_c   = 1'b1;
            ram_we_c   = 1'b1;
            ram_addr_c = col_q;
            ram0_din_c = pix_q;
            ram1_din_c = ram0_dout;
            row2_d     = pix_q;
            ocol_d     = col_q;
            eol_d      = (col_q == LAST_COL);
`ifdef LINEBUF_BORDER_ZERO_EN
            row1_d     = (row_q == '0)    ? '0 : ram0_dout;
            row0_d     = (row_q < ROW_MAX) ? '0 : ram1_dout;
            valid_d    = 1'b1;
`else
            row1_d     = ram0_dout;
            row0_d     = ram1_dout;
            valid_d    = (row_q >= ROW_MAX);
`endif
            if (col_q == LAST_COL) begin
               col_d = '0;
               if (row_q < ROW_MAX) row_d = row_q + ROW_CNT_W'(1);
            end else begin
               col_d = col_q + P_ADDR_WIDTH'(1);
            end
            state_d = S_RD;
         end
         default: state_d = S_RD;
      endcase

      ready_d = (state_d == S_RD);
   end

   assign i_ready   = ready_q;
   assign o_valid   = valid_q;
   assign o_eol     = eol_q;
   assign o_row0    = row0_q;
   assign o_row1    = row1_q;
   assign o_row2    = row2_q;
   assign o_col     = ocol_q;

   assign ram0_en   = ram_en_c;
   assign ram0_we   = ram_we_c;
   assign ram0_addr = ram_addr_c;
   assign ram0_din  = ram0_din_c;
   assign ram1_en   = ram_en_c;
   assign ram1_we   = ram_we_c;
   assign ram1_addr = ram_addr_c;
   assign ram1_din  = ram1_din_c;

endmodule : linebuf_window_ctrl

// File: tb/tb_linebuf_window_ctrl.sv
// Directed bench for linebuf_window_ctrl with 4-pixel rows and two
// behavioural 1-cycle RAMs. A frame-position model predicts every window
// column; literal expectations pin the model on key pixels.
module tb_linebuf_window_ctrl;

   localparam int unsigned RW = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 12;
`ifdef LINEBUF_BORDER_ZERO_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   logic          clka = 1'b0;
   logic          rsta_n = 1'b0;
   logic          i_valid = 1'b0;
   logic          i_sof = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic          i_ready, o_valid, o_eol;
   logic [DW-1:0] o_row0, o_row1, o_row2;
   logic [AW-1:0] o_col;
   logic          ram0_en, ram0_we, ram1_en, ram1_we;
   logic [AW-1:0] ram0_addr, ram1_addr;
   logic [DW-1:0] ram0_din, ram1_din, ram0_dout, ram1_dout;

   linebuf_window_ctrl #(.P_ROW_WIDTH(RW), .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
      .clka(clka), .rsta_n(rsta_n), .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
      .i_ready(i_ready), .o_valid(o_valid), .o_row0(o_row0), .o_row1(o_row1),
      .o_row2(o_row2), .o_col(o_col), .o_eol(o_eol),
      .ram0_en(ram0_en), .ram0_we(ram0_we), .ram0_addr(ram0_addr), .ram0_din(ram0_din),
      .ram0_dout(ram0_dout),
      .ram1_en(ram1_en), .ram1_we(ram1_we), .ram1_addr(ram1_addr), .ram1_din(ram1_din),
      .ram1_dout(ram1_dout)
   );

   always #5 clka = ~clka;

   // Behavioural read-first single-port RAMs, 1-cycle read latency.
   logic [DW-1:0] mem0 [0:(1<<AW)-1];
   logic [DW-1:0] mem1 [0:(1<<AW)-1];
   always @(posedge clka) begin
      if (ram0_en) begin
         ram0_dout <= mem0[ram0_addr];
         if (ram0_we) mem0[ram0_addr] <= ram0_din;
      end
      if (ram1_en) begin
         ram1_dout <= mem1[ram1_addr];
         if (ram1_we) mem1[ram1_addr] <= ram1_din;
      end
   end

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;

   always @(posedge clka) ncyc = ncyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: pixel positions since the last SOF, as a plain frame image.
   typedef struct {
      int r0; int r1; int r2; int col; int eol; int due;
   } exp_t;
   exp_t exp_q[$];
   int img [0:63][0:RW-1];
   int mr = 0;
   int mc = 0;

   task automatic model_push(input int d, input bit sof, input int acc);
      exp_t e;
      if (sof) begin mr = 0; mc = 0; end
      img[mr][mc] = d;
      if (BORDER || mr >= 2) begin
         e.r0  = (mr >= 2) ? img[mr-2][mc] : 0;
         e.r1  = (mr >= 1) ? img[mr-1][mc] : 0;
         e.r2  = d;
         e.col = mc;
         e.eol = (mc == RW-1) ? 1 : 0;
         e.due = acc + 2;
         exp_q.push_back(e);
      end
      mc = mc + 1;
      if (mc == RW) begin mc = 0; mr = mr + 1; end
   endtask

   // Per-pixel record of what the DUT emitted, keyed by the row-n pixel value.
   int s_hit [0:255];
   int s_r0  [0:255];
   int s_r1  [0:255];
   int s_col [0:255];
   int s_eol [0:255];
   int a_hit [0:255];
   int a_r0  [0:255];
   int a_r1  [0:255];
   int a_col [0:255];
   int a_eol [0:255];
   int vcount = 0;

   task automatic clear_seen();
      for (int i = 0; i < 256; i++) begin
         s_hit[i] = 0; s_r0[i] = -1; s_r1[i] = -1; s_col[i] = -1; s_eol[i] = -1;
      end
      vcount = 0;
   endtask

   // Compare process: every emitted column against the model, including latency.
   always @(negedge clka) begin
      if (rsta_n && o_valid) begin
         exp_t e;
         int p;
         p = int'(o_row2);
         vcount = vcount + 1;
         s_hit[p] = 1; s_r0[p] = int'(o_row0); s_r1[p] = int'(o_row1);
         s_col[p] = int'(o_col); s_eol[p] = int'(o_eol);
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("row2", int'(o_row2), e.r2);
            chk("row1", int'(o_row1), e.r1);
            chk("row0", int'(o_row0), e.r0);
            chk("col", int'(o_col), e.col);
            chk("eol", int'(o_eol), e.eol);
            chk("latency", ncyc, e.due);
         end
      end
   end

   int last_acc = 0;

   task automatic send(input int d, input bit sof);
      bit got;
      got = 1'b0;
      i_valid = 1'b1;
      i_data  = DW'(d);
      i_sof   = sof;
      for (int w = 0; w < 20 && !got; w++) begin
         @(negedge clka);
         if (i_ready) begin
            got = 1'b1;
            last_acc = ncyc;
            model_push(d, sof, ncyc);
         end
         @(posedge clka);
         #1;
      end
      if (!got) chk("accept_timeout", 0, 1);
      i_valid = 1'b0;
      i_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) @(posedge clka);
      #1;
   endtask

   int accs [0:11];

   initial begin
      clear_seen();
      // Reset values.
      #2;
      chk("rst_ready", int'(i_ready), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ram_en", int'(ram0_en | ram1_en), 0);
      chk("rst_ram_we", int'(ram0_we | ram1_we), 0);
      chk("rst_col", int'(o_col), 0);
      chk("rst_row2", int'(o_row2), 0);
      repeat (3) @(posedge clka);
      @(negedge clka);
      rsta_n = 1'b1;
      @(posedge clka);
      #1;
      chk("ready_after_rst", int'(i_ready), 1);

      // Frame fill, continuous i_valid.
      for (int p = 1; p <= 12; p++) begin
         send(p, p == 1);
         accs[p-1] = last_acc;
      end
      idle(6);
      for (int i = 1; i < 12; i++) chk("accept_spacing", accs[i] - accs[i-1], 2);
      if (BORDER) begin
         chk("fill_count", vcount, 12);
         chk("p1_row0", s_r0[1], 0);
         chk("p1_row1", s_r1[1], 0);
         chk("p5_row0", s_r0[5], 0);
         chk("p5_row1", s_r1[5], 1);
      end else begin
         chk("fill_count", vcount, 4);
         chk("p8_hit", s_hit[8], 0);
         chk("p9_row0", s_r0[9], 1);
         chk("p9_row1", s_r1[9], 5);
         chk("p12_row0", s_r0[12], 4);
         chk("p12_row1", s_r1[12], 8);
      end
      chk("p12_eol", s_eol[12], 1);
      chk("p9_col", s_col[9], 0);
      for (int i = 0; i < 256; i++) begin
         a_hit[i] = s_hit[i]; a_r0[i] = s_r0[i]; a_r1[i] = s_r1[i];
         a_col[i] = s_col[i]; a_eol[i] = s_eol[i];
      end

      // Same frame with 10 idle cycles between pixels.
      clear_seen();
      for (int p = 1; p <= 12; p++) begin
         send(p, p == 1);
         idle(10);
      end
      for (int p = 1; p <= 12; p++) begin
         chk("gap_hit", s_hit[p], a_hit[p]);
         if (a_hit[p] != 0) begin
            chk("gap_row0", s_r0[p], a_r0[p]);
            chk("gap_row1", s_r1[p], a_r1[p]);
            chk("gap_col", s_col[p], a_col[p]);
            chk("gap_eol", s_eol[p], a_eol[p]);
         end
      end

      // SOF on the 3rd pixel of row 2.
      clear_seen();
      for (int p = 101; p <= 110; p++) send(p, p == 101);
      send(120, 1'b1);
      for (int p = 121; p <= 128; p++) send(p, 1'b0);
      idle(6);
      if (BORDER) begin
         chk("sof_count", vcount, 19);
         chk("sof_col", s_col[120], 0);
         chk("sof_row0", s_r0[120], 0);
         chk("sof_row1", s_r1[120], 0);
      end else begin
         chk("sof_count", vcount, 3);
         chk("sof_hit", s_hit[120], 0);
         chk("p127_hit", s_hit[127], 0);
         chk("p128_hit", s_hit[128], 1);
         chk("p128_row0", s_r0[128], 120);
         chk("p128_row1", s_r1[128], 124);
      end
      chk("p128_col", s_col[128], 0);

      // Reset asserted during a write cycle.
      clear_seen();
      send(200, 1'b1);
      send(201, 1'b0);
      send(202, 1'b0);
      chk("wr_cycle_we", int'(ram0_we), 1);
      rsta_n = 1'b0;
      #1;
      chk("abort_we0", int'(ram0_we), 0);
      chk("abort_we1", int'(ram1_we), 0);
      chk("abort_valid", int'(o_valid), 0);
      chk("abort_ready", int'(i_ready), 0);
      exp_q.delete();
      mr = 0;
      mc = 0;
      repeat (3) @(posedge clka);
      @(negedge clka);
      rsta_n = 1'b1;
      @(posedge clka);
      #1;
      chk("ready_after_abort", int'(i_ready), 1);
      for (int p = 210; p <= 218; p++) send(p, 1'b0);
      idle(6);
      chk("post_rst_col0", s_col[210 + (BORDER ? 0 : 8)], 0);
      chk("p218_row0", s_r0[218], 210);
      chk("p218_row1", s_r1[218], 214);
      chk("no_stale_202", s_hit[202], 0);

      chk("pending", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule : tb_linebuf_window_ctrl
